scaler_gate_sched: RTL and testbench

- Schedules scaler count windows from the ~1 kHz scaler tick produced by the scaler clock divider in the clk33 domain.
- Each window spans a programmable number of ticks and drives the gate, latch and clear strobes for the scaler counter bank.
- Hands each latched result to the readout side through a ready/ack handshake, and flags windows the readout side misses.

---
 rtl/scaler_gate_sched_pkg.sv | 26 ++
 rtl/scaler_gate_sched_if.sv | 32 +++
 rtl/scaler_gate_sched_rdy_tracker.sv | 35 +++
 rtl/scaler_gate_sched.sv | 111 +++++++++++
 tb/tb_scaler_gate_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scaler_gate_sched_pkg.sv
// Shared types and constants for the scaler gate scheduler.
// State encoding, register widths and reset window length.
package scaler_gate_sched_pkg;

  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned SEQ_W    = 16;

  localparam logic [PERIOD_W-1:0] DEFAULT_PERIOD =
    PERIOD_W'(1000);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_COUNT = 3'd2,
    S_LATCH = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  // a programmed length of zero still closes after one tick
  function automatic logic [PERIOD_W-1:0] eff_period(
    input logic [PERIOD_W-1:0] p
  );
    return (p == '0) ? PERIOD_W'(1) : p;
  endfunction

endpackage

// File: rtl/scaler_gate_sched_if.sv
// Control and readout bundle between the scaler scheduler
// and its environment (tick source, host, counter bank).
interface scaler_gate_sched_if;

  logic                                  khz_tick_i;
  logic                                  enable_i;
  logic [scaler_gate_sched_pkg::PERIOD_W-1:0] period_i;
  logic                                  period_wr_i;
  logic                                  ack_i;
  logic                                  gate_o;
  logic                                  latch_o;
  logic                                  clear_o;
  logic                                  rdy_o;
  logic                                  missed_o;
  logic [scaler_gate_sched_pkg::SEQ_W-1:0]    seq_o;
  logic                                  busy_o;

  modport master (
    output khz_tick_i, enable_i, period_i,
    output period_wr_i, ack_i,
    input  gate_o, latch_o, clear_o,
    input  rdy_o, missed_o, seq_o, busy_o
  );

  modport slave (
    input  khz_tick_i, enable_i, period_i,
    input  period_wr_i, ack_i,
    output gate_o, latch_o, clear_o,
    output rdy_o, missed_o, seq_o, busy_o
  );

endinterface

// File: rtl/scaler_gate_sched_rdy_tracker.sv
// Readout handshake: window sequence number, ready flag
// and sticky overrun flag, driven by the latch strobe.
module scaler_rdy_tracker
  import scaler_gate_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             latch,
  input  logic             ack,
  output logic             rdy,
  output logic             missed,
  output logic [SEQ_W-1:0] seq
);

  logic take;

  assign take = ack & rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy    <= 1'b0;
      missed <= 1'b0;
      seq    <= '0;
    end else if (latch) begin
      rdy    <= 1'b1;
      seq    <= seq + SEQ_W'(1);
      // a same-cycle ack consumes the older window
      missed <= ~take & (missed | rdy);
    end else if (take) begin
      rdy    <= 1'b0;
      missed <= 1'b0;
    end
  end

endmodule

// File: rtl/scaler_gate_sched.sv
// Scaler count-window scheduler: gate/latch/clear strobes
// sequenced from the 1 kHz tick, plus readout tracking.
module scaler_gate_sched
  import scaler_gate_sched_pkg::*;
(
  input logic                clk33_i,
  input logic                rst_n_i,
  scaler_gate_sched_if.slave bus
);

  state_t              state;
  logic [PERIOD_W-1:0] pend_period;
  logic [PERIOD_W-1:0] act_period;
  logic [PERIOD_W-1:0] tick_cnt;
  logic [PERIOD_W-1:0] cnt_inc;
  logic                tick_pend;
  logic                tick_any;
  logic                gate;
  logic                latch;
  logic                clear;
  logic                rdy;
  logic                missed;
  logic [SEQ_W-1:0]    seq;

  assign tick_any = bus.khz_tick_i | tick_pend;
  assign cnt_inc  = tick_cnt + PERIOD_W'(1);

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      pend_period <= DEFAULT_PERIOD;
      act_period  <= DEFAULT_PERIOD;
      tick_cnt    <= '0;
      tick_pend   <= 1'b0;
      gate        <= 1'b0;
      latch       <= 1'b0;
      clear       <= 1'b0;
    end else begin
      latch <= 1'b0;
      clear <= 1'b0;
      if (bus.period_wr_i) pend_period <= bus.period_i;
      unique case (state)
        S_IDLE: begin
          if (bus.enable_i) state <= S_ARM;
        end
        S_ARM: begin
          if (!bus.enable_i) begin
            state <= S_IDLE;
          end else if (bus.khz_tick_i) begin
            act_period <= pend_period;
            tick_cnt   <= '0;
            gate       <= 1'b1;
            state      <= S_COUNT;
          end
        end
        S_COUNT: begin
          tick_pend <= 1'b0;
          if (tick_any) begin
            tick_cnt <= cnt_inc;
            if (cnt_inc == eff_period(act_period)) begin
              gate  <= 1'b0;
              latch <= 1'b1;
              state <= S_LATCH;
            end
          end
        end
        S_LATCH: begin
          if (bus.khz_tick_i) tick_pend <= 1'b1;
          clear <= 1'b1;
          state <= S_CLEAR;
        end
        S_CLEAR: begin
          act_period <= pend_period;
          tick_cnt   <= '0;
          if (bus.enable_i) begin
            if (bus.khz_tick_i) tick_pend <= 1'b1;
            gate  <= 1'b1;
            state <= S_COUNT;
          end else begin
            tick_pend <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          gate      <= 1'b0;
          tick_pend <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  scaler_rdy_tracker u_rdy (
    .clk    (clk33_i),
    .rst_n  (rst_n_i),
    .latch  (latch),
    .ack    (bus.ack_i),
    .rdy    (rdy),
    .missed (missed),
    .seq    (seq)
  );

  assign bus.gate_o   = gate;
  assign bus.latch_o  = latch;
  assign bus.clear_o  = clear;
  assign bus.rdy_o    = rdy;
  assign bus.missed_o = missed;
  assign bus.seq_o    = seq;
  assign bus.busy_o   = (state != S_IDLE);

endmodule

// File: tb/tb_scaler_gate_sched.sv
// Scoreboard bench for scaler_gate_sched: window-level model
// pushes expected latches, a monitor checks DUT strobes.
module tb_scaler_gate_sched;
  import scaler_gate_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #15 clk = ~clk;

  scaler_gate_sched_if bus ();

  scaler_gate_sched dut (
    .clk33_i (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int len;
    int seq;
    bit rdy;
    bit missed;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  int pend_m;
  int cur_len_m;
  int carry_m;
  int seq_m;
  bit unread_m;
  bit missed_m;

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int eff(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic void model_reset();
    pend_m    = 1000;
    cur_len_m = 1000;
    carry_m   = 0;
    seq_m     = 0;
    unread_m  = 1'b0;
    missed_m  = 1'b0;
  endfunction

  // one completed window as the readout side should see it
  function automatic void expect_latch(input int len,
                                       input bit ack_lat);
    exp_t e;
    seq_m = (seq_m + 1) % 65536;
    if (unread_m && ack_lat) missed_m = 1'b0;
    else if (unread_m) missed_m = 1'b1;
    unread_m = 1'b1;
    e.len = len;
    e.seq = seq_m;
    e.rdy = 1'b1;
    e.missed = missed_m;
    sb.push_back(e);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    bus.khz_tick_i = 1'b1;
    cyc();
    bus.khz_tick_i = 1'b0;
  endtask

  task automatic write_period(input int v);
    bus.period_i    = PERIOD_W'(v);
    bus.period_wr_i = 1'b1;
    cyc();
    bus.period_wr_i = 1'b0;
    pend_m = v;
  endtask

  task automatic check_idle();
    repeat (4) cyc();
    @(negedge clk);
    chk("idle_busy", bus.busy_o, 0);
    chk("idle_gate", bus.gate_o, 0);
    cyc();
  endtask

  task automatic start();
    bus.enable_i = 1'b1;
    cyc();
    repeat ($urandom_range(0, 3)) cyc();
    pulse_tick();
    @(negedge clk);
    chk("gate_rise_after_arm_tick", bus.gate_o, 1);
    chk("busy_in_count", bus.busy_o, 1);
    cur_len_m = eff(pend_m);
    carry_m   = 0;
    repeat (3) cyc();
  endtask

  task automatic do_window(input bit ack_lat,
                           input bit ack_after,
                           input bit stop_in,
                           input bit wr,
                           input int wr_p,
                           input bit cl_in,
                           input int gap,
                           output bit stopped);
    int len, need, g;
    bit stop, cl_tick;
    stop = stop_in;
    cl_tick = cl_in;
    len  = cur_len_m;
    need = len - carry_m;
    carry_m = 0;
    if (need == 0) begin
      stop = 1'b0;
      cl_tick = 1'b0;
    end
    stopped = stop;
    for (int k = 1; k <= need; k++) begin
      if (stop && k == need / 2 + 1) bus.enable_i = 1'b0;
      if (k == need) expect_latch(len, ack_lat);
      pulse_tick();
      if (k < need) begin
        g = (gap > 0) ? gap : $urandom_range(4, 8);
        if (wr && k == 1) begin
          write_period($urandom_range(0, 9));
          write_period(wr_p);
          g -= 2;
        end
        repeat (g) cyc();
      end
    end
    if (need > 0) begin
      bus.ack_i = ack_lat;
      cyc();
      bus.ack_i = 1'b0;
      if (!stop) cur_len_m = eff(pend_m);
      if (cl_tick) begin
        // this tick lands in CLEAR and opens the next window
        if (!stop) begin
          carry_m = 1;
          if (cur_len_m == 1) expect_latch(1, 1'b0);
        end
        pulse_tick();
      end
      repeat ($urandom_range(4, 8)) cyc();
    end else begin
      cur_len_m = eff(pend_m);
    end
    if (ack_after) begin
      bus.ack_i = 1'b1;
      cyc();
      bus.ack_i = 1'b0;
      if (unread_m) begin
        unread_m = 1'b0;
        missed_m = 1'b0;
      end
      @(negedge clk);
      chk("rdy_after_ack", bus.rdy_o, unread_m);
      chk("missed_after_ack", bus.missed_o, missed_m);
      cyc();
    end
    if (stop) begin
      carry_m = 0;
      check_idle();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gate"}, bus.gate_o, 0);
    chk({tag, "_latch"}, bus.latch_o, 0);
    chk({tag, "_clear"}, bus.clear_o, 0);
    chk({tag, "_rdy"}, bus.rdy_o, 0);
    chk({tag, "_missed"}, bus.missed_o, 0);
    chk({tag, "_seq"}, bus.seq_o, 0);
    chk({tag, "_busy"}, bus.busy_o, 0);
  endtask

  // monitor: measures each window and checks the readout state
  initial begin : monitor
    int   cur;
    bit   carry, have, prev_gate, prev_latch;
    exp_t e;
    cur = 0;
    carry = 0;
    have = 0;
    prev_gate = 0;
    prev_latch = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur = 0;
        carry = 0;
        have = 0;
        prev_gate = 0;
        prev_latch = 0;
      end else begin
        if (bus.gate_o && !prev_gate) begin
          cur = carry ? 1 : 0;
          carry = 0;
        end
        if (bus.gate_o && bus.khz_tick_i) cur++;
        if ((bus.latch_o || bus.clear_o) && bus.khz_tick_i)
          carry = 1;
        if (!bus.busy_o) carry = 0;
        if (bus.latch_o) begin
          chk("gate_low_in_latch", bus.gate_o, 0);
          chk("latch_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            have = 1;
            chk("window_len", cur, e.len);
          end
          cur = 0;
        end
        if (bus.clear_o) begin
          chk("clear_after_latch", prev_latch, 1);
          chk("gate_low_in_clear", bus.gate_o, 0);
          if (have) begin
            chk("seq", bus.seq_o, e.seq);
            chk("rdy", bus.rdy_o, e.rdy);
            chk("missed", bus.missed_o, e.missed);
            have = 0;
          end
        end
        prev_gate = bus.gate_o;
        prev_latch = bus.latch_o;
      end
    end
  end

  initial begin : watchdog
    #(30 * 90000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit st;
    bus.khz_tick_i  = 1'b0;
    bus.enable_i    = 1'b0;
    bus.period_i    = '0;
    bus.period_wr_i = 1'b0;
    bus.ack_i       = 1'b0;
    model_reset();
    repeat (3) cyc();
    @(negedge clk);
    check_reset_outputs("reset");
    cyc();
    rst_n = 1'b1;
    cyc();

    // period 3, then period 2 windows with missed/ack
    write_period(3);
    start();
    do_window(0, 0, 0, 1, 2, 0, 0, st);
    do_window(0, 1, 0, 0, 0, 0, 0, st);
    do_window(0, 0, 0, 0, 0, 0, 0, st);
    do_window(1, 0, 0, 1, 5, 0, 0, st);
    // enable dropped mid-window of period 5
    do_window(0, 0, 1, 0, 0, 0, 0, st);

    // period 4 then 0, with a tick landing in CLEAR
    write_period(4);
    start();
    do_window(0, 1, 0, 1, 0, 1, 0, st);
    st = 0;
    while (!st) do_window(0, 0, 1, 0, 0, 0, 0, st);

    // enable dropped while still armed
    bus.enable_i = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    chk("arm_busy", bus.busy_o, 1);
    cyc();
    bus.enable_i = 1'b0;
    cyc();
    pulse_tick();
    check_idle();

    // asynchronous reset in the middle of a window
    write_period(6);
    start();
    pulse_tick();
    repeat (3) cyc();
    #4 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sb.delete();
    model_reset();
    bus.enable_i = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    start();
    do_window(0, 0, 1, 0, 0, 0, 2, st);

    // randomized runs
    for (int r = 0; r < 16; r++) begin
      int nwin, w;
      if ($urandom_range(0, 2) == 0)
        write_period($urandom_range(0, 6));
      start();
      nwin = $urandom_range(1, 4);
      w = 0;
      st = 0;
      while (!st) begin
        do_window($urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1,
                  w >= nwin - 1,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 6),
                  $urandom_range(0, 3) == 0,
                  0, st);
        w++;
      end
      if ($urandom_range(0, 1) == 1) begin
        bus.ack_i = 1'b1;
        cyc();
        bus.ack_i = 1'b0;
        unread_m = 1'b0;
        missed_m = 1'b0;
        @(negedge clk);
        chk("idle_ack_rdy", bus.rdy_o, 0);
        chk("idle_ack_missed", bus.missed_o, 0);
        chk("idle_ack_seq", bus.seq_o, seq_m);
        cyc();
      end
    end

    repeat (20) cyc();
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
